dual_port_bram_be: RTL and testbench
====================================

// Module: dual_port_bram_be
// PURPOSE
//  Second-generation true dual-port block RAM for on-chip caches and scratchpads.
//  Two independent read/write ports with per-byte write enables and a selectable read-during-write mode.
//  Read latency is configurable at 1 or 2 cycles, with a read-valid flag per port.
//  A same-address write collision detector and a saturating collision counter support debug.
// PARAMETERS
//  DATA_WIDTH    32  word width in bits; must be a multiple of 8
//  ADDR_WIDTH    8   address bits; depth = 2**ADDR_WIDTH words
//  READ_LATENCY  1   1 = registered read; 2 = extra output register stage
//  RDW_MODE      0   0 = write-first (new data returned); 1 = read-first (old data returned)
//  CNT_WIDTH     16  width of collisionCount
// PORTS
//  clock           in   1             single clock; all state updates on posedge
//  reset           in   1             asynchronous, active-low reset
//  readEnable_N    in   1             port N read request (N = 1, 2)
//  writeEnable_N   in   1             port N write request
//  byteEnable_N    in   DATA_WIDTH/8  port N write byte lanes; ignored unless writeEnable_N = 1
//  address_N       in   ADDR_WIDTH    port N word address
//  writeData_N     in   DATA_WIDTH    port N write data
//  readData_N      out  DATA_WIDTH    port N read data
//  readValid_N     out  1             readData_N carries the result of a read request
//  collision       out  1             registered pulse: both ports wrote overlapping lanes at one address
//  collisionCount  out  CNT_WIDTH     saturating count of collision events
// BEHAVIOUR
//  Reset (reset = 0, asynchronous):
//   - readData_N, any stage-2 registers, readValid_N, collision and collisionCount clear to 0.
//   - Memory array is not cleared.
//   - On release, the first request is accepted on the next posedge.
//   - A read in flight when reset asserts is discarded; its readValid never asserts.
//  Write at posedge:
//   - For each lane b with writeEnable_N & byteEnable_N[b], mem[address_N] lane b <= writeData_N lane b.
//  Collision (same address, both writeEnable = 1):
//   - Merge per lane. A lane enabled on both ports takes port 1 data.
//   - A lane enabled on one port only takes that port's data.
//   - collision asserts for 1 cycle (the cycle after) only if at least one lane is enabled on both ports.
//   - collisionCount increments with it and saturates at all-ones without wrapping.
//  Read:
//   - readEnable_N at posedge T captures mem[address_N].
//   - READ_LATENCY = 1: readData_N and readValid_N valid after posedge T.
//   - READ_LATENCY = 2: valid after posedge T+1, and fully pipelined (one read per port per cycle).
//   - readValid_N is 1 exactly for cycles carrying a new read result, otherwise 0.
//   - readData_N holds its last value when no read completes. Writes alone never change readData_N.
//  Read-during-write (any port reading an address written this cycle by either port):
//   - RDW_MODE 0: returns the fully merged post-write word, both ports' lanes and collision merge applied.
//   - RDW_MODE 1: returns the pre-write word.
//  Simultaneous reads of the same address with no write: both ports return the same stored word.
//  Address wrap: no range check. All ADDR_WIDTH values are valid, and 2**ADDR_WIDTH-1 is a normal word.
//  No back-pressure: requests are accepted every cycle unconditionally.
// TESTING
//  1. Reset then read addr 0x05 with readEnable_1 = 1 and no prior write.
//     -> readValid_1 = 1 after the latency; collision = 0; collisionCount = 0.
//  2. P1 writes 0x0000000A @0 and P2 writes 0x0000000B @1 with byteEnable = 4'hF, then both read.
//     -> readData_1 = 0x0A, readData_2 = 0x0B. readData is unchanged during the write cycle.
//  3. Byte merge: write 0x11223344 @3 with BE 4'hF, then 0xAABBCCDD @3 with BE 4'b0101.
//     -> read @3 returns 0x11BB33DD.
//  4. Collision, RDW_MODE 0: both ports write @0 with BE F, P1 = 0x1, P2 = 0x2, both read enabled.
//     -> readData_1 = readData_2 = 0x1; collision pulses once; collisionCount = 1.
//  5. Partial collision: P1 BE 4'b0011 = 0x0000AAAA, P2 BE 4'b1110 = 0xBBBB0000 @7.
//     -> mem[7] lanes: [3:2] = 0xBBBB, [1:0] = 0xAAAA; collision = 1 (lane 1 shared).
//     -> Repeat with P2 BE 4'b1100 -> collision = 0, count unchanged.
//  6. READ_LATENCY = 2, RDW_MODE 1, back-to-back reads @0..@3 with a write to @2 in the same cycle as its read.
//     -> 4 consecutive readValid pulses starting 2 cycles later; @2 returns the old value.
//     -> Assert reset mid-stream -> all outputs 0 immediately; no further readValid.
//  Also: with CNT_WIDTH = 2, force 5 collisions -> collisionCount holds 3.

Source files
------------

// File: rtl/dual_port_bram_be.sv
// True dual-port block RAM with per-byte write enables, 1/2-cycle read latency,
// selectable read-during-write behaviour and a same-address write collision counter.
module dual_port_bram_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter int CNT_WIDTH    = 16
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    readEnable_1,
    input  logic                    writeEnable_1,
    input  logic [DATA_WIDTH/8-1:0] byteEnable_1,
    input  logic [ADDR_WIDTH-1:0]   address_1,
    input  logic [DATA_WIDTH-1:0]   writeData_1,
    output logic [DATA_WIDTH-1:0]   readData_1,
    output logic                    readValid_1,
    input  logic                    readEnable_2,
    input  logic                    writeEnable_2,
    input  logic [DATA_WIDTH/8-1:0] byteEnable_2,
    input  logic [ADDR_WIDTH-1:0]   address_2,
    input  logic [DATA_WIDTH-1:0]   writeData_2,
    output logic [DATA_WIDTH-1:0]   readData_2,
    output logic                    readValid_2,
    output logic                    collision,
    output logic [CNT_WIDTH-1:0]    collisionCount
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Index 0 = port 1, index 1 = port 2.
    logic [1:0]                      rdEn, wrEn, rdValid;
    logic [1:0][NUM_LANES-1:0]       be;
    logic [1:0][ADDR_WIDTH-1:0]      addr;
    logic [1:0][DATA_WIDTH-1:0]      wrData, rdData;

    assign rdEn   = {readEnable_2, readEnable_1};
    assign wrEn   = {writeEnable_2, writeEnable_1};
    assign be     = {byteEnable_2, byteEnable_1};
    assign addr   = {address_2, address_1};
    assign wrData = {writeData_2, writeData_1};

    assign readData_1  = rdData[0];
    assign readData_2  = rdData[1];
    assign readValid_1 = rdValid[0];
    assign readValid_2 = rdValid[1];

    // Port 2 is applied first so port 1 wins any lane both ports enable.
    always_ff @(posedge clock) begin
        for (int p = 1; p >= 0; p--) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (wrEn[p] && be[p][b])
                    mem[addr[p]][b*8 +: 8] <= wrData[p][b*8 +: 8];
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0]                      oldWord, newWord, capWord;
        logic [READ_LATENCY:1]                      vldPipe;
        logic [READ_LATENCY:1][DATA_WIDTH-1:0]      dataPipe;

        assign oldWord = mem[addr[p]];

        // Post-write view of this port's address, with the same lane priority as the array.
        always_comb begin
            newWord = oldWord;
            for (int q = 1; q >= 0; q--) begin
                for (int b = 0; b < NUM_LANES; b++) begin
                    if (wrEn[q] && be[q][b] && addr[q] == addr[p])
                        newWord[b*8 +: 8] = wrData[q][b*8 +: 8];
                end
            end
        end

        assign capWord = (RDW_MODE == 0) ? newWord : oldWord;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                vldPipe  <= '0;
                dataPipe <= '0;
            end else begin
                vldPipe[1] <= rdEn[p];
                if (rdEn[p]) dataPipe[1] <= capWord;
                for (int s = 2; s <= READ_LATENCY; s++) begin
                    vldPipe[s] <= vldPipe[s-1];
                    if (vldPipe[s-1]) dataPipe[s] <= dataPipe[s-1];
                end
            end
        end

        assign rdData[p]  = dataPipe[READ_LATENCY];
        assign rdValid[p] = vldPipe[READ_LATENCY];
    end

    logic collisionHit;
    assign collisionHit = writeEnable_1 && writeEnable_2 && (address_1 == address_2)
                          && |(byteEnable_1 & byteEnable_2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            collision      <= 1'b0;
            collisionCount <= '0;
        end else begin
            collision <= collisionHit;
            if (collisionHit && collisionCount != {CNT_WIDTH{1'b1}})
                collisionCount <= collisionCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_dual_port_bram_be.sv
// Directed bench: default config (a), latency-2 read-first config (b), 2-bit counter config (c, shares a's stimulus).
module tb_dual_port_bram_be;
    logic clock = 1'b0;
    logic rst = 1'b1, rstB = 1'b1;
    always #5 clock = ~clock;

    logic        rdEn1 = 0, wrEn1 = 0, rdEn2 = 0, wrEn2 = 0;
    logic [3:0]  be1 = 0, be2 = 0;
    logic [7:0]  ad1 = 0, ad2 = 0;
    logic [31:0] wd1 = 0, wd2 = 0;
    logic [31:0] rd1, rd2, cRd1, cRd2;
    logic        rv1, rv2, col, cRv1, cRv2, cCol;
    logic [15:0] cnt;
    logic [1:0]  cCnt;

    logic        bRdEn1 = 0, bWrEn1 = 0, bRdEn2 = 0, bWrEn2 = 0;
    logic [3:0]  bBe1 = 0, bBe2 = 0;
    logic [7:0]  bAd1 = 0, bAd2 = 0;
    logic [31:0] bWd1 = 0, bWd2 = 0;
    logic [31:0] bRd1, bRd2;
    logic        bRv1, bRv2, bCol;
    logic [15:0] bCnt;

    int total = 0, bad = 0;

    dual_port_bram_be u0 (.clock(clock), .reset(rst),
        .readEnable_1(rdEn1), .writeEnable_1(wrEn1), .byteEnable_1(be1), .address_1(ad1), .writeData_1(wd1),
        .readData_1(rd1), .readValid_1(rv1),
        .readEnable_2(rdEn2), .writeEnable_2(wrEn2), .byteEnable_2(be2), .address_2(ad2), .writeData_2(wd2),
        .readData_2(rd2), .readValid_2(rv2), .collision(col), .collisionCount(cnt));

    dual_port_bram_be #(.READ_LATENCY(2), .RDW_MODE(1)) u1 (.clock(clock), .reset(rstB),
        .readEnable_1(bRdEn1), .writeEnable_1(bWrEn1), .byteEnable_1(bBe1), .address_1(bAd1), .writeData_1(bWd1),
        .readData_1(bRd1), .readValid_1(bRv1),
        .readEnable_2(bRdEn2), .writeEnable_2(bWrEn2), .byteEnable_2(bBe2), .address_2(bAd2), .writeData_2(bWd2),
        .readData_2(bRd2), .readValid_2(bRv2), .collision(bCol), .collisionCount(bCnt));

    dual_port_bram_be #(.CNT_WIDTH(2)) u2 (.clock(clock), .reset(rst),
        .readEnable_1(rdEn1), .writeEnable_1(wrEn1), .byteEnable_1(be1), .address_1(ad1), .writeData_1(wd1),
        .readData_1(cRd1), .readValid_1(cRv1),
        .readEnable_2(rdEn2), .writeEnable_2(wrEn2), .byteEnable_2(be2), .address_2(ad2), .writeData_2(wd2),
        .readData_2(cRd2), .readValid_2(cRv2), .collision(cCol), .collisionCount(cCnt));

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic idle;
        rdEn1 = 0; wrEn1 = 0; rdEn2 = 0; wrEn2 = 0; be1 = 0; be2 = 0;
    endtask

    task automatic test_reset;
        #1 rst = 0; rstB = 0; #1;
        total++; if (rd1 !== 0 || rd2 !== 0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", rd1, rd2); end
        total++; if (rv1 !== 0 || rv2 !== 0 || bRv1 !== 0 || bRv2 !== 0) begin bad++; $display("FAIL reset_valid got=%b%b%b%b exp=0", rv1, rv2, bRv1, bRv2); end
        total++; if (col !== 0 || cnt !== 0 || cCnt !== 0) begin bad++; $display("FAIL reset_col got=%b/%0d/%0d exp=0", col, cnt, cCnt); end
        tick(); #2 rst = 1; rstB = 1;
    endtask

    task automatic test_read_unwritten;
        rdEn1 = 1; ad1 = 8'h05; tick();
        total++; if (rv1 !== 1 || rv2 !== 0) begin bad++; $display("FAIL unwritten_valid got=%b%b exp=10", rv1, rv2); end
        total++; if (col !== 0 || cnt !== 0) begin bad++; $display("FAIL unwritten_col got=%b/%0d exp=0/0", col, cnt); end
        idle(); tick();
        total++; if (rv1 !== 0) begin bad++; $display("FAIL valid_drop got=%b exp=0", rv1); end
    endtask

    task automatic test_write_read;
        wrEn1 = 1; be1 = 4'hF; ad1 = 0; wd1 = 32'hA;
        wrEn2 = 1; be2 = 4'hF; ad2 = 1; wd2 = 32'hB; tick();
        total++; if (rv1 !== 0 || rv2 !== 0) begin bad++; $display("FAIL write_no_valid got=%b%b exp=00", rv1, rv2); end
        idle(); rdEn1 = 1; ad1 = 0; rdEn2 = 1; ad2 = 1; tick();
        total++; if (rd1 !== 32'hA || rv1 !== 1) begin bad++; $display("FAIL read_p1 got=%h exp=0000000a", rd1); end
        total++; if (rd2 !== 32'hB || rv2 !== 1) begin bad++; $display("FAIL read_p2 got=%h exp=0000000b", rd2); end
        idle(); wrEn1 = 1; be1 = 4'hF; ad1 = 0; wd1 = 32'h77;
        wrEn2 = 1; be2 = 4'hF; ad2 = 8'hFF; wd2 = 32'h5A5AA5A5; tick();
        total++; if (rd1 !== 32'hA || rd2 !== 32'hB) begin bad++; $display("FAIL write_hold got=%h/%h exp=a/b", rd1, rd2); end
        idle(); rdEn1 = 1; ad1 = 8'hFF; rdEn2 = 1; ad2 = 0; tick();
        total++; if (rd1 !== 32'h5A5AA5A5 || rd2 !== 32'h77) begin bad++; $display("FAIL addr_max got=%h/%h exp=5a5aa5a5/77", rd1, rd2); end
        idle();
    endtask

    task automatic test_byte_merge;
        wrEn1 = 1; be1 = 4'hF; ad1 = 3; wd1 = 32'h11223344; tick();
        be1 = 4'b0101; wd1 = 32'hAABBCCDD; tick();
        idle(); rdEn1 = 1; ad1 = 3; rdEn2 = 1; ad2 = 3; tick();
        total++; if (rd1 !== 32'h11BB33DD) begin bad++; $display("FAIL byte_merge got=%h exp=11bb33dd", rd1); end
        total++; if (rd2 !== 32'h11BB33DD) begin bad++; $display("FAIL same_addr_read got=%h exp=11bb33dd", rd2); end
        idle();
    endtask

    task automatic test_rdw_write_first;
        wrEn1 = 1; be1 = 4'hF; ad1 = 9; wd1 = 32'hCAFEF00D; tick();
        be1 = 4'b0011; wd1 = 32'h99995678; rdEn2 = 1; ad2 = 9; tick();
        total++; if (rd2 !== 32'hCAFE5678) begin bad++; $display("FAIL rdw_first got=%h exp=cafe5678", rd2); end
        idle();
    endtask

    task automatic test_collision;
        wrEn1 = 1; wrEn2 = 1; be1 = 4'hF; be2 = 4'hF; ad1 = 0; ad2 = 0; wd1 = 32'h1; wd2 = 32'h2;
        rdEn1 = 1; rdEn2 = 1; tick();
        total++; if (rd1 !== 32'h1 || rd2 !== 32'h1) begin bad++; $display("FAIL col_rdw got=%h/%h exp=1/1", rd1, rd2); end
        total++; if (col !== 1 || cnt !== 1) begin bad++; $display("FAIL col_pulse got=%b/%0d exp=1/1", col, cnt); end
        idle(); tick();
        total++; if (col !== 0 || cnt !== 1) begin bad++; $display("FAIL col_once got=%b/%0d exp=0/1", col, cnt); end
    endtask

    task automatic test_partial;
        wrEn1 = 1; be1 = 4'b0011; wd1 = 32'h0000AAAA; ad1 = 7;
        wrEn2 = 1; be2 = 4'b1110; wd2 = 32'hBBBB0000; ad2 = 7; tick();
        total++; if (col !== 1 || cnt !== 2) begin bad++; $display("FAIL partial_col got=%b/%0d exp=1/2", col, cnt); end
        idle(); rdEn1 = 1; ad1 = 7; tick();
        total++; if (rd1 !== 32'hBBBBAAAA) begin bad++; $display("FAIL partial_merge got=%h exp=bbbbaaaa", rd1); end
        idle(); wrEn1 = 1; be1 = 4'b0011; ad1 = 7; wrEn2 = 1; be2 = 4'b1100; ad2 = 7; tick();
        total++; if (col !== 0 || cnt !== 2) begin bad++; $display("FAIL disjoint_col got=%b/%0d exp=0/2", col, cnt); end
        idle();
    endtask

    task automatic test_saturate;
        wrEn1 = 1; wrEn2 = 1; be1 = 4'h1; be2 = 4'h1; ad1 = 8'h20; ad2 = 8'h20;
        repeat (5) tick();
        idle(); tick();
        total++; if (cCnt !== 2'd3) begin bad++; $display("FAIL saturate got=%0d exp=3", cCnt); end
        total++; if (cnt !== 16'd7) begin bad++; $display("FAIL count_wide got=%0d exp=7", cnt); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            bWrEn1 = 1; bBe1 = 4'hF; bAd1 = 8'(i); bWd1 = 32'h100 + i; tick();
        end
        bWrEn1 = 0;
        for (int i = 0; i < 4; i++) begin
            bRdEn1 = 1; bAd1 = 8'(i);
            bWrEn2 = (i == 2); bBe2 = 4'hF; bAd2 = 2; bWd2 = 32'hDEAD;
            tick();
            if (i == 0) begin
                total++; if (bRv1 !== 0) begin bad++; $display("FAIL lat2_early got=%b exp=0", bRv1); end
            end else begin
                total++; if (bRv1 !== 1 || bRd1 !== 32'h100 + i - 1) begin bad++; $display("FAIL lat2_rd%0d got=%b/%h exp=1/%h", i - 1, bRv1, bRd1, 32'h100 + i - 1); end
            end
        end
        bRdEn1 = 0; bWrEn2 = 0; tick();
        total++; if (bRv1 !== 1 || bRd1 !== 32'h103) begin bad++; $display("FAIL lat2_rd3 got=%b/%h exp=1/103", bRv1, bRd1); end
        tick();
        total++; if (bRv1 !== 0 || bRd1 !== 32'h103) begin bad++; $display("FAIL lat2_hold got=%b/%h exp=0/103", bRv1, bRd1); end
        bRdEn1 = 1; bAd1 = 2; tick();
        bAd1 = 3; tick();
        total++; if (bRv1 !== 1 || bRd1 !== 32'hDEAD) begin bad++; $display("FAIL lat2_new got=%b/%h exp=1/dead", bRv1, bRd1); end
        bRdEn1 = 0; #2 rstB = 0; #1;
        total++; if (bRv1 !== 0 || bRd1 !== 0 || bCnt !== 0) begin bad++; $display("FAIL midreset got=%b/%h/%0d exp=0", bRv1, bRd1, bCnt); end
        #3 rstB = 1; tick(); tick();
        total++; if (bRv1 !== 0 || bRv2 !== 0) begin bad++; $display("FAIL post_reset_valid got=%b%b exp=00", bRv1, bRv2); end
    endtask

    initial begin
        test_reset();
        test_read_unwritten();
        test_write_read();
        test_byte_merge();
        test_rdw_write_first();
        test_collision();
        test_partial();
        test_saturate();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
